// File: rtl/btn_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_sched_pkg
//  Purpose  : Shared definitions for the button event scheduler:
//             FSM state encodings, channel limit and an id-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package btn_sched_pkg;

    // Scheduler FSM state encodings
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    // Largest supported number of button channels
    localparam int MAX_BTN = 16;

    // Bits needed to index n channels (ceil(log2(n)), same result as $clog2)
    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin search. Returns the first set request
//             bit at or above ptr, wrapping from N_BTN-1 back to 0.
//  Ports    : req   [N_BTN] - request vector
//             ptr   [IDW]   - search start position (0..N_BTN-1)
//             found         - at least one request is set
//             idx   [IDW]   - index of the selected request (0 when none)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_BTN = 4,
    parameter int IDW   = 2
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/btn_event_sched.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_sched
//  Purpose  : Latches debounced press ticks from N_BTN buttons into pending
//             flags and serialises them round-robin onto one valid/ready
//             event stream. Optional long-press detection is built when the
//             macro BTN_LONG_PRESS_EN is defined.
//  Ports    : clk, reset (async, active-high)
//             db_level [N_BTN] - debounced button levels
//             db_tick  [N_BTN] - one-cycle press ticks
//             ev_valid / ev_ready - event handshake
//             ev_id    [IDW]   - button index of the presented event
//             ev_long          - 1 = long-press event, 0 = press event
//             ev_ovf           - sticky: an event was merged/dropped
//  Macro    : BTN_LONG_PRESS_EN - per-button hold counters and long events
//  Revision : 1.0  initial release
// ============================================================================
module btn_event_sched
    import btn_sched_pkg::*;
#(
    parameter int N_BTN  = 4,
    parameter int IDW    = 2,
    parameter int HOLD_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] db_level,
    input  logic [N_BTN-1:0] db_tick,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDW-1:0]   ev_id,
    output logic             ev_long,
    output logic             ev_ovf
);

    if (N_BTN < 2 || N_BTN > MAX_BTN || IDW != id_width(N_BTN)) begin : g_param_err
        $error("btn_event_sched: N_BTN must be 2..16 and IDW must equal clog2(N_BTN)");
    end

    logic [0:0]       r_state;
    logic             r_ev_valid;
    logic [IDW-1:0]   r_ev_id;
    logic             r_ev_long;
    logic             r_ev_ovf;
    logic [IDW-1:0]   r_ptr;
    logic [N_BTN-1:0] r_press_pend;

    logic [N_BTN-1:0] w_req;
    logic [N_BTN-1:0] w_sel;
    logic [N_BTN-1:0] w_clr_press;
    logic [N_BTN-1:0] w_clr_long;
    logic [N_BTN-1:0] w_ovf_press;
    logic [N_BTN-1:0] w_ovf_long;
    logic             w_accept;
    logic             w_found;
    logic [IDW-1:0]   w_idx;
    logic             w_pick_long;
    logic [IDW-1:0]   w_ptr_next;

    assign w_accept = r_ev_valid & ev_ready;

    // One-hot decode of the presented id, used to clear the served flag
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_sel
        assign w_sel[gi] = (r_ev_id == IDW'(gi));
    end

    assign w_clr_press = w_sel & {N_BTN{w_accept & ~r_ev_long}};
    assign w_clr_long  = w_sel & {N_BTN{w_accept &  r_ev_long}};

    // A tick on a flag that is cleared in the same cycle re-arms it and is
    // not counted as an overflow.
    assign w_ovf_press = db_tick & r_press_pend & ~w_clr_press;

    assign w_ptr_next = (r_ev_id == IDW'(N_BTN - 1)) ? '0 : r_ev_id + IDW'(1);

`ifdef BTN_LONG_PRESS_EN
    localparam logic [HOLD_W-1:0] c_HOLD_MAX = '1;
    localparam logic [HOLD_W-1:0] c_HOLD_SET = c_HOLD_MAX - HOLD_W'(1);

    logic [N_BTN-1:0] r_long_pend;
    logic [N_BTN-1:0] w_long_set;

    // Hold counter per button: restarts on a tick, counts while the level is
    // high and sticks at all-ones so each hold yields a single long event.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_hold
        logic [HOLD_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (db_tick[gi]) begin
                r_cnt <= '0;
            end else if (db_level[gi] && (r_cnt != c_HOLD_MAX)) begin
                r_cnt <= r_cnt + HOLD_W'(1);
            end
        end

        // Fires on the increment that reaches all-ones
        assign w_long_set[gi] = !db_tick[gi] && db_level[gi] && (r_cnt == c_HOLD_SET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_long_pend <= '0;
        end else begin
            r_long_pend <= (r_long_pend & ~w_clr_long) | w_long_set;
        end
    end

    assign w_ovf_long  = w_long_set & r_long_pend & ~w_clr_long;
    assign w_req       = r_press_pend | r_long_pend;
    // Serve the press before the long press of the same button
    assign w_pick_long = ~r_press_pend[w_idx];
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{db_level, w_clr_long};
    assign w_ovf_long      = '0;
    assign w_req           = r_press_pend;
    assign w_pick_long     = 1'b0;
`endif

    rr_pick #(
        .N_BTN (N_BTN),
        .IDW   (IDW)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ev_valid   <= 1'b0;
            r_ev_id      <= '0;
            r_ev_long    <= 1'b0;
            r_ev_ovf     <= 1'b0;
            r_ptr        <= '0;
            r_press_pend <= '0;
        end else begin
            r_press_pend <= (r_press_pend & ~w_clr_press) | db_tick;

            if (|(w_ovf_press | w_ovf_long)) begin
                r_ev_ovf <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_ev_id    <= w_idx;
                        r_ev_long  <= w_pick_long;
                        r_ev_valid <= 1'b1;
                        r_state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    // id/long stay frozen until the consumer takes the event
                    if (w_accept) begin
                        r_ev_valid <= 1'b0;
                        r_ptr      <= w_ptr_next;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_ev_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_id    = r_ev_id;
    assign ev_long  = r_ev_long;
    assign ev_ovf   = r_ev_ovf;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event_sched
//  Purpose  : Self-checking bench for btn_event_sched. A cycle table covers
//             single press, simultaneous presses and round-robin ordering;
//             hand-written sequences cover overflow merge, same-cycle
//             re-tick, asynchronous reset mid-handshake and (with
//             BTN_LONG_PRESS_EN) long-press detection.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_sched;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int HW = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  db_level;
    logic [N-1:0]  db_tick;
    logic          ev_valid;
    logic          ev_ready;
    logic [IW-1:0] ev_id;
    logic          ev_long;
    logic          ev_ovf;

    btn_event_sched #(
        .N_BTN  (N),
        .IDW    (IW),
        .HOLD_W (HW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .db_level (db_level),
        .db_tick  (db_tick),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_id    (ev_id),
        .ev_long  (ev_long),
        .ev_ovf   (ev_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] tick;
        logic       ready;
        logic       rst;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic       exp_ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        db_tick  = '0;
        db_level = '0;
        ev_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_cnt;
        int acc_id;
        int ev_c;
        int ev_idq[4];
        int ev_lq[4];
        int ev_cyc[4];

        reset    = 1'b1;
        db_level = '0;
        db_tick  = '0;
        ev_ready = 1'b0;

        // Outputs checked at the start of each row, then the row's inputs
        // are driven for the following edge.
        //                tick    rdy   rst   valid id    ovf
        vecs[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[6]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
        vecs[14] = '{4'b1001, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
        vecs[16] = '{4'b1001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[18] = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[19] = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[20] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[21] = '{4'b1000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        vecs[22] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[23] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[24] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[25] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
        vecs[26] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_ovf", int'(ev_ovf), 0);
        reset = 1'b0;

        // ---------------- table-driven section ----------------
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            check($sformatf("v%0d_valid", k), int'(ev_valid), int'(vecs[k].exp_valid));
            check($sformatf("v%0d_id", k), int'(ev_id), int'(vecs[k].exp_id));
            check($sformatf("v%0d_long", k), int'(ev_long), 0);
            check($sformatf("v%0d_ovf", k), int'(ev_ovf), int'(vecs[k].exp_ovf));
            db_tick  = vecs[k].tick;
            ev_ready = vecs[k].ready;
            reset    = vecs[k].rst;
        end

        // ---------------- overflow and merge ----------------
        do_reset();
        db_tick = 4'b0010;
        @(negedge clk);
        db_tick = 4'b0000;
        @(negedge clk);
        db_tick = 4'b0010;
        @(negedge clk);
        db_tick  = 4'b0000;
        ev_ready = 1'b1;
        check("ovf_set", int'(ev_ovf), 1);
        acc_cnt = 0;
        acc_id  = -1;
        for (int i = 0; i < 10; i++) begin
            if (ev_valid && ev_ready) begin
                acc_cnt++;
                acc_id = int'(ev_id);
            end
            @(negedge clk);
        end
        check("ovf_merge_count", acc_cnt, 1);
        check("ovf_merge_id", acc_id, 1);

        // ---------------- same-cycle clear and re-tick ----------------
        do_reset();
        ev_ready = 1'b1;
        db_tick  = 4'b0010;
        @(negedge clk);
        db_tick = 4'b0000;
        check("sc_idle_valid", int'(ev_valid), 0);
        @(negedge clk);
        check("sc_first_valid", int'(ev_valid), 1);
        check("sc_first_id", int'(ev_id), 1);
        db_tick = 4'b0010;
        @(negedge clk);
        db_tick = 4'b0000;
        acc_cnt = 0;
        acc_id  = -1;
        for (int i = 0; i < 8; i++) begin
            if (ev_valid && ev_ready) begin
                acc_cnt++;
                acc_id = int'(ev_id);
            end
            @(negedge clk);
        end
        check("sc_second_count", acc_cnt, 1);
        check("sc_second_id", acc_id, 1);
        check("sc_no_ovf", int'(ev_ovf), 0);

        // ---------------- reset mid-handshake ----------------
        do_reset();
        db_tick = 4'b0100;
        @(negedge clk);
        db_tick = 4'b0000;
        @(negedge clk);
        check("rm_valid", int'(ev_valid), 1);
        db_tick = 4'b0100;
        @(negedge clk);
        db_tick = 4'b0000;
        check("rm_ovf_before", int'(ev_ovf), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rm_valid_async", int'(ev_valid), 0);
        check("rm_ovf_async", int'(ev_ovf), 0);
        check("rm_id_async", int'(ev_id), 0);
        @(negedge clk);
        reset    = 1'b0;
        ev_ready = 1'b1;
        acc_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            if (ev_valid) acc_cnt++;
            @(negedge clk);
        end
        check("rm_no_event", acc_cnt, 0);

`ifdef BTN_LONG_PRESS_EN
        // ---------------- long press: 20-cycle hold ----------------
        do_reset();
        ev_ready = 1'b1;
        db_tick  = 4'b0001;
        db_level = 4'b0001;
        ev_c = 0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (c == 1)  db_tick  = 4'b0000;
            if (c == 20) db_level = 4'b0000;
            if (ev_valid && ev_ready) begin
                if (ev_c < 4) begin
                    ev_idq[ev_c] = int'(ev_id);
                    ev_lq[ev_c]  = int'(ev_long);
                    ev_cyc[ev_c] = c;
                end
                ev_c++;
            end
        end
        check("lp_count", ev_c, 2);
        check("lp_first_id", ev_idq[0], 0);
        check("lp_first_long", ev_lq[0], 0);
        check("lp_first_cyc", ev_cyc[0], 2);
        check("lp_second_id", ev_idq[1], 0);
        check("lp_second_long", ev_lq[1], 1);
        check("lp_second_cyc", ev_cyc[1], 17);
        check("lp_no_ovf", int'(ev_ovf), 0);

        // ---------------- long press: 10-cycle hold ----------------
        do_reset();
        ev_ready = 1'b1;
        db_tick  = 4'b0001;
        db_level = 4'b0001;
        ev_c    = 0;
        acc_cnt = 0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (c == 1)  db_tick  = 4'b0000;
            if (c == 10) db_level = 4'b0000;
            if (ev_valid && ev_ready) begin
                ev_c++;
                if (ev_long) acc_cnt++;
            end
        end
        check("sh_count", ev_c, 1);
        check("sh_long_count", acc_cnt, 0);
`else
        ev_c = 0;
        ev_idq = '{0, 0, 0, 0};
        ev_lq  = '{0, 0, 0, 0};
        ev_cyc = '{0, 0, 0, 0};
        // Held level without the long-press build must never raise ev_long
        do_reset();
        ev_ready = 1'b1;
        db_tick  = 4'b0001;
        db_level = 4'b0001;
        acc_cnt  = 0;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (c == 1) db_tick = 4'b0000;
            if (ev_valid && ev_ready) begin
                ev_c++;
                if (ev_long) acc_cnt++;
            end
        end
        check("nl_count", ev_c, 1);
        check("nl_long_count", acc_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
